// File: rtl/exec_mc_unit_pkg.sv
// Purpose: shared op codes, status bit positions and FSM states for the execute stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_mc_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIVU = 3'd3,
        OP_REMU = 3'd4,
        OP_AND  = 3'd5,
        OP_OR   = 3'd6,
        OP_XOR  = 3'd7
    } op_e;

    localparam int S_N = 3;
    localparam int S_Z = 2;
    localparam int S_C = 1;
    localparam int S_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Packs the four flags into their architectural bit positions.
    function automatic logic [3:0] mk_status(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] s;
        s      = 4'b0000;
        s[S_N] = n;
        s[S_Z] = z;
        s[S_C] = c;
        s[S_V] = v;
        return s;
    endfunction

endpackage

// File: rtl/exec_mc_unit_div_iter.sv
// Purpose: restoring unsigned divider datapath, one quotient bit per cycle.
// Latency: W cycles after start; quo/rem are the post-iteration values while done is high.
// Backpressure: none; the caller must not restart it while it iterates.
// Ports: start loads a/b; done marks the final iteration; quo/rem are combinational step results.
module div_iter #(
    parameter int W     = 32,
    parameter int W_CNT = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);

    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     b_q;
    logic [W_CNT-1:0] cnt_q;
    logic [W:0]       shifted;
    logic [W:0]       trial;
    logic             fits;

    // Partial remainder is always < b, so the shifted value fits in W+1 bits
    // and the top bit of the trial difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, b_q};
        fits    = ~trial[W];
        rem     = fits ? trial[W-1:0] : shifted[W-1:0];
        quo     = {quo_q[W-2:0], fits};
    end

    assign done = (cnt_q == W_CNT'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= a;
            b_q   <= b;
            cnt_q <= W_CNT'(W);
        end else if (cnt_q != '0) begin
            rem_q <= rem;
            quo_q <= quo;
            cnt_q <= cnt_q - W_CNT'(1);
        end
    end

endmodule

// File: rtl/exec_mc_unit.sv
// Purpose: execute stage: single-cycle ALU, iterative unsigned divide, sticky halt, NZCV status.
// Latency: 1 cycle for ALU ops and divide-by-zero, W+1 cycles for DIVU/REMU.
// Backpressure: ready_o drops while dividing or halted; decode holds its op until accepted.
// Ports: v_i/ready_o issue handshake; op_i/dest_i/src_i/wb_i/rd_i/halt_i op fields;
//        wb_o/wb_rd_name_o/wb_rd_data_o writeback; status_o NZCV; busy_o/halted_o state.
module exec_mc_unit
    import exec_mc_unit_pkg::*;
#(
    parameter int W    = 32,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [W-1:0]    dest_i,
    input  logic [W-1:0]    src_i,
    input  logic            wb_i,
    input  logic [W_RD-1:0] rd_i,
    input  logic            halt_i,
    output logic            wb_o,
    output logic [W_RD-1:0] wb_rd_name_o,
    output logic [W-1:0]    wb_rd_data_o,
    output logic [3:0]      status_o,
    output logic            busy_o,
    output logic            halted_o
);

    localparam int W_CNT = $clog2(W+1);

    state_e          state_q, state_d;
    logic            div_start;
    logic            issue_alu;
    logic            div_done;
    logic [W-1:0]    div_quo, div_rem, div_r;
    logic            rem_sel_q;
    logic            wb_q;
    logic [W_RD-1:0] rd_q;

    logic [W:0]      sum, diff;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    alu_r;
    logic            alu_c, alu_v;

    assign ready_o  = (state_q == ST_IDLE);
    assign busy_o   = (state_q == ST_DIV);
    assign halted_o = (state_q == ST_HALT);

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    if (halt_i) begin
                        state_d = ST_HALT;
                    end else if ((op_i == OP_DIVU || op_i == OP_REMU) && src_i != '0) begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ST_DIV:  if (div_done) state_d = ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign issue_alu = ready_o & v_i & ~halt_i & ~div_start;

    always_comb begin
        sum   = {1'b0, dest_i} + {1'b0, src_i};
        diff  = {1'b0, dest_i} - {1'b0, src_i};
        prod  = {{W{1'b0}}, dest_i} * {{W{1'b0}}, src_i};
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_r = sum[W-1:0];
                alu_c = sum[W];
                alu_v = (dest_i[W-1] == src_i[W-1]) && (sum[W-1] != dest_i[W-1]);
            end
            OP_SUB: begin
                alu_r = diff[W-1:0];
                alu_c = ~diff[W];
                alu_v = (dest_i[W-1] != src_i[W-1]) && (diff[W-1] != dest_i[W-1]);
            end
            OP_MUL: begin
                alu_r = prod[W-1:0];
                alu_c = (prod[2*W-1:W] != '0);
                alu_v = alu_c;
            end
            // Only reached here for a zero divisor; nonzero divisors go to the iterator.
            OP_DIVU: begin
                alu_r = '1;
                alu_v = 1'b1;
            end
            OP_REMU: begin
                alu_r = dest_i;
                alu_v = 1'b1;
            end
            OP_AND:  alu_r = dest_i & src_i;
            OP_OR:   alu_r = dest_i | src_i;
            OP_XOR:  alu_r = dest_i ^ src_i;
            default: alu_r = '0;
        endcase
    end

    div_iter #(.W(W), .W_CNT(W_CNT)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (dest_i),
        .b     (src_i),
        .done  (div_done),
        .quo   (div_quo),
        .rem   (div_rem)
    );

    assign div_r = rem_sel_q ? div_rem : div_quo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rem_sel_q    <= 1'b0;
            wb_q         <= 1'b0;
            rd_q         <= '0;
            wb_o         <= 1'b0;
            wb_rd_name_o <= '0;
            wb_rd_data_o <= '0;
            status_o     <= '0;
        end else begin
            state_q <= state_d;
            wb_o    <= 1'b0;
            if (div_start) begin
                rem_sel_q <= (op_i == OP_REMU);
                wb_q      <= wb_i;
                rd_q      <= rd_i;
            end
            if (issue_alu) begin
                wb_o         <= wb_i;
                wb_rd_name_o <= rd_i;
                wb_rd_data_o <= alu_r;
                status_o     <= mk_status(alu_r[W-1], alu_r == '0, alu_c, alu_v);
            end else if (state_q == ST_DIV && div_done) begin
                wb_o         <= wb_q;
                wb_rd_name_o <= rd_q;
                wb_rd_data_o <= div_r;
                status_o     <= mk_status(div_r[W-1], div_r == '0, 1'b0, 1'b0);
            end
        end
    end

endmodule
